// File: rtl/seq_mult_8bits_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult_8bits_pkg
// Shared definitions for the sequential shift-add multiplier:
//   MULT_W  operand width (the fixed ripple-carry adder is 8 bits wide)
//   CNT_W   iteration counter width
//   state_t FSM state encoding (IDLE, RUN, DONE)
//   shift_step() one-bit right shift of the {carry, sum, acc_lo} chain
// ----------------------------------------------------------------------------
package seq_mult_8bits_pkg;

    localparam int MULT_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Drop the consumed multiplier bit: {c,s,acc_lo} (2W+1 bits) shifted right by one.
    // The carry lands in the MSB of the new accumulator, so nothing is lost.
    function automatic logic [2*MULT_W-1:0] shift_step(
        input logic [MULT_W:0]   carry_sum,
        input logic [MULT_W-1:0] acc_lo
    );
        return {carry_sum, acc_lo[MULT_W-1:1]};
    endfunction

endpackage

// File: rtl/seq_mult_8bits_rca.sv
// ----------------------------------------------------------------------------
// seq_mult_8bits_rca
// 8-bit ripple-carry adder used by the multiplier datapath.
// Ports:
//   a, b  in  [7:0]  addends
//   cin   in         carry in
//   sum   out [7:0]  a + b + cin (low 8 bits)
//   cout  out        carry out
// ----------------------------------------------------------------------------
module seq_mult_8bits_rca (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry_s;

    // Full-adder chain, carry rippling from bit 0 upward.
    always_comb begin
        carry_s    = 9'd0;
        sum        = 8'd0;
        carry_s[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[8];
    end

endmodule

// File: rtl/seq_mult_8bits.sv
// ----------------------------------------------------------------------------
// seq_mult_8bits
// Sequential shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One multiplier bit is consumed per clock; a start/busy/done handshake
// connects it to the controller.
// Ports:
//   clk      in             rising-edge clock
//   rst_n    in             asynchronous active-low reset
//   start    in             request; a/b sampled when accepted (IDLE or DONE)
//   a        in  [W-1:0]    multiplicand
//   b        in  [W-1:0]    multiplier
//   busy     out            high while iterating (RUN)
//   done     out            one-cycle pulse, product valid (DONE)
//   product  out [2W-1:0]   result, held until the next completed multiply
// ----------------------------------------------------------------------------
module seq_mult_8bits
    import seq_mult_8bits_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;
    logic [WIDTH:0]       add_s;
    logic [2*WIDTH-1:0]   step_s;

    // The adder always sees acc_hi and mcand; gating happens on its output.
    seq_mult_8bits_rca u_rca (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Select the add result only when the current multiplier bit is set.
    always_comb begin
        add_s = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) begin
            add_s = {cout_s, sum_s};
        end else begin
            add_s = {1'b0, acc_hi_q};
        end
        step_s = shift_step(add_s, acc_lo_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE with start pending behaves like IDLE: back-to-back issue.
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = {WIDTH{1'b0}};
                    acc_lo_d = b;
                    count_d  = {CNT_W{1'b0}};
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_hi_d = step_s[2*WIDTH-1:WIDTH];
                acc_lo_d = step_s[WIDTH-1:0];
                count_d  = count_q + 4'd1;
                if (count_q == LAST_CNT) begin
                    // Product is captured only on entry to DONE.
                    product_d = step_s;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are registered copies of the next state's decode.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= 4'd0;
            mcand_q   <= 8'd0;
            acc_hi_q  <= 8'd0;
            acc_lo_q  <= 8'd0;
            product_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8bits.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_8bits
// Self-checking bench for seq_mult_8bits: directed cases plus a random sweep,
// every result compared with a plain a*b reference model.
// ----------------------------------------------------------------------------
module tb_seq_mult_8bits;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a     = 8'd0;
    logic [7:0]  b     = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks = 0;
    int n_errors = 0;
    int done_total = 0;

    seq_mult_8bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Single comparison point: count, and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain unsigned product.
    function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Continuous monitor: done pulse counting and busy/done exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_total++;
            chk("busy_and_done", {31'd0, busy && done}, 32'd0);
        end
    end

    // Issue one multiply and check latency, busy length, result and pulse width.
    task automatic run_mult(input logic [7:0] x, input logic [7:0] y, input string tag);
        int  lat;
        int  busy_cycles;
        bit  seen;
        logic [15:0] exp_p;
        exp_p = ref_mult(x, y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        busy_cycles = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = k + 1;
                break;
            end
            if (busy) busy_cycles++;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, lat, 32'd9);
            chk({tag, "_busy_cycles"}, busy_cycles, 32'd8);
            chk({tag, "_product"}, {16'd0, product}, {16'd0, exp_p});
            @(posedge clk);
            #1;
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_product_hold"}, {16'd0, product}, {16'd0, exp_p});
        end
    endtask

    initial begin
        int d0;
        int wait_cnt;
        bit got;
        logic [7:0] rx, ry;

        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: reset during RUN cycle 4 of 13*11
        @(negedge clk);
        a = 8'd13; b = 8'd11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t1_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_busy_async", {31'd0, busy}, 32'd0);
        chk("t1_done_async", {31'd0, done}, 32'd0);
        chk("t1_product_async", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_total;
        repeat (15) @(negedge clk);
        chk("t1_no_done_after_reset", done_total - d0, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Test 2-4: basic, carry path, zeros
        run_mult(8'd13,  8'd11,  "t2_13x11");
        chk("t2_value", {16'd0, product}, 32'h008F);
        run_mult(8'd255, 8'd255, "t3_ffxff");
        chk("t3_value", {16'd0, product}, 32'hFE01);
        run_mult(8'd255, 8'd1,   "t3_ffx1");
        run_mult(8'd128, 8'd2,   "t3_128x2");
        run_mult(8'd0,   8'd200, "t4_0x200");
        run_mult(8'd200, 8'd0,   "t4_200x0");

        // Test 5: start while RUN is ignored
        d0 = done_total;
        @(negedge clk);
        a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd7; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("t5_done_seen", {31'd0, got}, 32'd1);
        chk("t5_product", {16'd0, product}, {16'd0, ref_mult(8'd3, 8'd5)});
        repeat (15) @(negedge clk);
        chk("t5_single_done", done_total - d0, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Test 6: back-to-back via DONE with start held
        @(negedge clk);
        a = 8'd6; b = 8'd7; start = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("t6_first_done", {31'd0, got}, 32'd1);
        chk("t6_first_product", {16'd0, product}, 32'h002A);
        @(negedge clk);
        a = 8'd9; b = 8'd9;
        @(posedge clk);
        #1;
        chk("t6_restart_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!done) chk("t6_product_stable", {16'd0, product}, 32'h002A);
            @(posedge clk);
            #1;
            wait_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("t6_second_done", {31'd0, got}, 32'd1);
        chk("t6_second_gap", wait_cnt, 32'd9);
        chk("t6_second_product", {16'd0, product}, 32'h0051);

        // Random sweep against the reference model
        for (int i = 0; i < 24; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom_range(0, 255));
            run_mult(rx, ry, "rand");
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
